// File: rtl/seg7_display_pkg.sv
// Shared types and the hex-to-segment lookup for the 7-segment display slice.
// Segment bit order: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;
  localparam seg_t SEG_ALL = 7'h7F;

  // Active-high glyphs for 0..F (lower-case b and d keep them distinct from 8 and 0).
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_display_if.sv
// Nibble-in / segments-out bundle between the conversion datapath and the display driver.
interface seg7_display_if;
  import display_pkg::*;

  logic [3:0] binary_code;
  logic       blank;
  logic       lamp_test;
  seg_t       display_code;

  modport master (output binary_code, output blank, output lamp_test, input display_code);
  modport slave  (input binary_code, input blank, input lamp_test, output display_code);

endinterface

// File: rtl/seg7_display_gray2bin.sv
// 4-bit Gray-to-binary converter, purely combinational; used by seg7_display
// only when GRAY_INPUT_EN is defined.
module gray2bin (
  input  logic [3:0] gray,
  output logic [3:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin[3] = gray[3];
    bin[2] = bin[3] ^ gray[2];
    bin[1] = bin[2] ^ gray[1];
    bin[0] = bin[1] ^ gray[0];
  end

endmodule

// File: rtl/seg7_display.sv
// Registered hex-to-7-segment decoder with blank / lamp-test override and
// selectable output polarity.
// Optional build macro: GRAY_INPUT_EN -- binary_code is Gray-coded and is
// converted to binary before the lookup (latency unchanged).
module seg7_display
  import display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_display_if.slave  bus
);

  // Polarity is a plain XOR mask so reset and run paths share one definition of "off".
  localparam seg_t POL_MASK = SEG_ACTIVE_LOW ? SEG_ALL : SEG_OFF;

  logic [3:0] nibble;
  seg_t       seg_next;
  seg_t       seg_q;

`ifdef GRAY_INPUT_EN
  gray2bin u_gray2bin (
    .gray (bus.binary_code),
    .bin  (nibble)
  );
`else
  assign nibble = bus.binary_code;
`endif

  // Priority mux (lamp_test > blank > glyph), then polarity, ahead of the register.
  always_comb begin
    // NOTE: assign a default first so every path writes seg_next and no latch is inferred.
    seg_next = hex_to_seg(nibble);
    if (bus.lamp_test) begin
      seg_next = SEG_ALL;
    end else if (bus.blank) begin
      seg_next = SEG_OFF;
    end
    seg_next = seg_next ^ POL_MASK;
  end

  // Output register: glitch-free pin drive; reset blanks the digit immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignment for state so all flops sample the same pre-edge values.
      seg_q <= SEG_OFF ^ POL_MASK;
    end else begin
      seg_q <= seg_next;
    end
  end

  assign bus.display_code = seg_q;

endmodule

// File: tb/tb_seg7_display.sv
// Directed self-checking bench for seg7_display. Two instances share stimulus:
// dut_h (active-high segments) and dut_l (active-low segments).
// Honours GRAY_INPUT_EN when the bench is built with the same macro.
module tb_seg7_display;
  import display_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  seg7_display_if bus_h ();
  seg7_display_if bus_l ();

  seg7_display #(.SEG_ACTIVE_LOW(1'b0)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));
  seg7_display #(.SEG_ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written glyph table, indexed by the binary value shown on the digit.
  logic [6:0] glyph [16];
  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Value the digit represents for a given input code under the current build.
  function automatic logic [3:0] shown_value(input logic [3:0] code);
`ifdef GRAY_INPUT_EN
    logic [3:0] b;
    b[3] = code[3];
    b[2] = b[3] ^ code[2];
    b[1] = b[2] ^ code[1];
    b[0] = b[1] ^ code[0];
    return b;
`else
    return code;
`endif
  endfunction

  task automatic drive(input logic [3:0] code, input logic bl, input logic lt);
    bus_h.binary_code = code; bus_h.blank = bl; bus_h.lamp_test = lt;
    bus_l.binary_code = code; bus_l.blank = bl; bus_l.lamp_test = lt;
  endtask

  // Apply inputs on the falling edge, sample #1 after the next rising edge.
  task automatic apply(input logic [3:0] code, input logic bl, input logic lt);
    @(negedge clk);
    drive(code, bl, lt);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [6:0] hi, input logic [6:0] exp_hi);
    n_vec++;
    if (bus_h.display_code !== exp_hi) begin
      n_bad++;
      $display("FAIL %s (active-high): got %h expected %h", name, bus_h.display_code, exp_hi);
    end
    n_vec++;
    if (bus_l.display_code !== ~exp_hi) begin
      n_bad++;
      $display("FAIL %s (active-low): got %h expected %h", name, bus_l.display_code, ~exp_hi);
    end
    if (hi !== bus_h.display_code) begin
      $display("note: %s sampled value changed during compare", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'h8, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_hold", bus_h.display_code, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp("reset_release", bus_h.display_code, glyph[shown_value(4'h8)]);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      apply(4'(i), 1'b0, 1'b0);
      cmp($sformatf("sweep_%0h", i), bus_h.display_code, glyph[shown_value(4'(i))]);
    end
  endtask

  task automatic test_priority();
    apply(4'h1, 1'b1, 1'b0);
    cmp("blank", bus_h.display_code, 7'h00);
    apply(4'h1, 1'b1, 1'b1);
    cmp("lamp_over_blank", bus_h.display_code, 7'h7F);
    apply(4'h1, 1'b0, 1'b1);
    cmp("lamp_only", bus_h.display_code, 7'h7F);
    apply(4'h1, 1'b0, 1'b0);
    cmp("clear_overrides", bus_h.display_code, glyph[shown_value(4'h1)]);
  endtask

  task automatic test_polarity();
    apply(4'h0, 1'b0, 1'b0);
    n_vec++;
    if (bus_l.display_code !== 7'h40) begin
      n_bad++;
      $display("FAIL polarity_zero: got %h expected %h", bus_l.display_code, 7'h40);
    end
  endtask

  task automatic test_async_reset();
    apply(4'h5, 1'b0, 1'b1);
    cmp("pre_async_lamp", bus_h.display_code, 7'h7F);
    apply(4'h5, 1'b0, 1'b0);
    cmp("pre_async", bus_h.display_code, glyph[shown_value(4'h5)]);
    #2;
    rst_n = 1'b0;
    drive(4'h5, 1'b0, 1'b1);
    #1;
    cmp("async_reset", bus_h.display_code, 7'h00);
    @(negedge clk);
    cmp("async_reset_held", bus_h.display_code, 7'h00);
    rst_n = 1'b1;
    drive(4'h5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cmp("after_async", bus_h.display_code, glyph[shown_value(4'h5)]);
  endtask

  task automatic test_back_to_back();
    apply(4'hA, 1'b0, 1'b0);
    cmp("b2b_a", bus_h.display_code, glyph[shown_value(4'hA)]);
    apply(4'hD, 1'b0, 1'b0);
    cmp("b2b_d", bus_h.display_code, glyph[shown_value(4'hD)]);
    apply(4'h3, 1'b1, 1'b0);
    cmp("b2b_blank", bus_h.display_code, 7'h00);
    apply(4'hE, 1'b0, 1'b0);
    cmp("b2b_e", bus_h.display_code, glyph[shown_value(4'hE)]);
  endtask

`ifdef GRAY_INPUT_EN
  task automatic test_gray();
    apply(4'b0011, 1'b0, 1'b0);
    cmp("gray_0011", bus_h.display_code, 7'h5B);
    apply(4'b1000, 1'b0, 1'b0);
    cmp("gray_1000", bus_h.display_code, 7'h71);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(4'h0, 1'b0, 1'b0);
    test_reset();
    test_sweep();
    test_priority();
    test_polarity();
    test_async_reset();
    test_back_to_back();
`ifdef GRAY_INPUT_EN
    test_gray();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
